// File: rtl/irs_sample_phase_monitor_if.sv
// Bus bundle for the IRS sample-phase monitor: measurement controls in, averaged phase results out.
interface irs_sample_phase_monitor_if #(
    parameter int NUM_IRS   = 4,
    parameter int MON_WIDTH = 8
);
    logic                           en_i;
    logic [NUM_IRS-1:0]             sample_mon_i;
    logic                           sync_i;
    logic [NUM_IRS*MON_WIDTH-1:0]   mon_o;
    logic                           mon_valid_o;
    logic [NUM_IRS-1:0]             err_o;
    logic                           busy_o;

    // mon_valid_o is a one-cycle strobe with no ready: the consumer must take
    // mon_o/err_o on that cycle; both hold steady between strobes.
    modport master (
        output en_i, sample_mon_i, sync_i,
        input  mon_o, mon_valid_o, err_o, busy_o
    );

    modport slave (
        input  en_i, sample_mon_i, sync_i,
        output mon_o, mon_valid_o, err_o, busy_o
    );
endinterface

// File: rtl/irs_sample_phase_monitor.sv
// Measures sync-to-first-rising-edge delay per sample_mon line and averages it
// over 2^AVG_LOG2 sync windows, flagging windows where a line showed no edge.
module irs_sample_phase_monitor #(
    parameter int NUM_IRS   = 4,
    parameter int MON_WIDTH = 8,
    parameter int AVG_LOG2  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    irs_sample_phase_monitor_if.slave bus
);
    localparam int ACC_W = MON_WIDTH + AVG_LOG2;
    localparam int WC_W  = AVG_LOG2 + 1;
    localparam logic [MON_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WC_W-1:0]      WIN_LAST = WC_W'((1 << AVG_LOG2) - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [NUM_IRS-1:0]   prev_q, edge_w, got_q, miss_q;
    logic [MON_WIDTH-1:0] cnt_q, phase_w;
    logic [MON_WIDTH-1:0] cap_q [NUM_IRS];
    logic [ACC_W-1:0]     acc_q [NUM_IRS];
    logic [ACC_W-1:0]     sum_w [NUM_IRS];
    logic [WC_W-1:0]      win_q;
    logic [NUM_IRS*MON_WIDTH-1:0] mon_q;
    logic [NUM_IRS-1:0]   err_q;
    logic                 valid_q;
    logic                 close_w, arm_w, drop_w;

    assign edge_w  = bus.sample_mon_i & ~prev_q;
    // phase_w is the delay of the current cycle from the last sync; cnt_q holds the previous one
    assign phase_w = bus.sync_i ? '0 :
                     (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + MON_WIDTH'(1);
    assign close_w = (state_q == RUN) && bus.en_i && bus.sync_i;
    assign arm_w   = (state_q == IDLE) && bus.en_i && bus.sync_i;
    assign drop_w  = (state_q == RUN) && !bus.en_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.en_i && bus.sync_i) state_d = RUN;
            RUN:     if (!bus.en_i)              state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A missing edge contributes the saturated phase to the average.
    always_comb begin
        for (int k = 0; k < NUM_IRS; k++) begin
            sum_w[k] = acc_q[k] + ACC_W'(got_q[k] ? cap_q[k] : CNT_MAX);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= bus.sample_mon_i;
            cnt_q  <= phase_w;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            got_q   <= '0;
            miss_q  <= '0;
            win_q   <= '0;
            mon_q   <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
            for (int k = 0; k < NUM_IRS; k++) begin
                cap_q[k] <= '0;
                acc_q[k] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            if (drop_w) begin
                got_q  <= '0;
                miss_q <= '0;
                win_q  <= '0;
                for (int k = 0; k < NUM_IRS; k++) acc_q[k] <= '0;
            end else if (close_w) begin
                if (win_q == WIN_LAST) begin
                    for (int k = 0; k < NUM_IRS; k++) begin
                        mon_q[k*MON_WIDTH +: MON_WIDTH] <= MON_WIDTH'(sum_w[k] >> AVG_LOG2);
                        acc_q[k] <= '0;
                    end
                    err_q   <= miss_q | ~got_q;
                    valid_q <= 1'b1;
                    miss_q  <= '0;
                    win_q   <= '0;
                end else begin
                    for (int k = 0; k < NUM_IRS; k++) acc_q[k] <= sum_w[k];
                    miss_q <= miss_q | ~got_q;
                    win_q  <= win_q + WC_W'(1);
                end
                // An edge on the sync cycle opens the new window with phase 0
                got_q <= edge_w;
                for (int k = 0; k < NUM_IRS; k++) cap_q[k] <= '0;
            end else if (arm_w) begin
                got_q <= edge_w;
                for (int k = 0; k < NUM_IRS; k++) cap_q[k] <= '0;
            end else if (state_q == RUN) begin
                for (int k = 0; k < NUM_IRS; k++) begin
                    if (edge_w[k] && !got_q[k]) begin
                        cap_q[k] <= phase_w;
                        got_q[k] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.mon_o       = mon_q;
    assign bus.err_o       = err_q;
    assign bus.mon_valid_o = valid_q;
    assign bus.busy_o      = (state_q == RUN);
endmodule

// File: tb/tb_irs_sample_phase_monitor.sv
// Directed bench for irs_sample_phase_monitor: sync-framed windows of edge stimulus,
// expected averages pushed at each closing sync and checked by a strobe monitor.
module tb_irs_sample_phase_monitor;
    localparam int W = 52;  // {strobe cycle[15:0], err[3:0], mon[31:0]}
    typedef int lane_t [4];

    logic        clk;
    logic        rst;
    logic [15:0] cyc;
    int          n_checks;
    int          n_fail;
    logic [W-1:0] exp_q [$];

    irs_sample_phase_monitor_if #(.NUM_IRS(4), .MON_WIDTH(8)) bus ();

    irs_sample_phase_monitor #(.NUM_IRS(4), .MON_WIDTH(8), .AVG_LOG2(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = '0;
    always @(posedge clk) cyc <= cyc + 16'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
    endfunction

    function automatic bit hit(input int t, input int e);
        return (e >= 0) && (t >= e) && (t < e + 3);
    endfunction

    // One sync window: sync on t=0, 3-cycle pulses starting at e1/e2 per lane.
    // If push is set, the sync at t=0 closes an average and the strobe is expected next cycle.
    task automatic win(input int period, input lane_t e1, input lane_t e2, input bit push,
                       input logic [31:0] emon, input logic [3:0] eerr, input int rst_at);
        for (int t = 0; t < period; t++) begin
            @(negedge clk);
            bus.sync_i = (t == 0);
            for (int k = 0; k < 4; k++) bus.sample_mon_i[k] = hit(t, e1[k]) | hit(t, e2[k]);
            rst = (rst_at >= 0) && (t >= rst_at) && (t < rst_at + 2);
            if (t == 0 && push) exp_q.push_back({cyc + 16'd1, eerr, emon});
        end
    endtask

    task automatic step(input bit s, input bit e);
        @(negedge clk);
        bus.sync_i       = s;
        bus.en_i         = e;
        bus.sample_mon_i = '0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (bus.mon_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("strobe_cycle", 64'(cyc), 64'(e[51:36]));
                check("mon", 64'(bus.mon_o), 64'(e[31:0]));
                check("err", 64'(bus.err_o), 64'(e[35:32]));
            end
        end
    end

    initial begin
        lane_t no, d1, f5, g1, g2, s280, l1, bad1;
        lane_t c20, c21, c22, c23;
        no   = '{-1, -1, -1, -1};
        d1   = '{10, 11, 12, 13};
        c20  = '{10, 11, 20, 13};
        c21  = '{10, 11, 21, 13};
        c22  = '{10, 11, 22, 13};
        c23  = '{10, 11, 23, 13};
        bad1 = '{5, -1, 5, 5};
        f5   = '{5, 5, 5, 5};
        g1   = '{5, 0, 7, 9};
        g2   = '{40, -1, -1, -1};
        s280 = '{280, 280, 280, 280};
        l1   = '{1, 2, 3, 4};
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.en_i = 1'b0;
        bus.sync_i = 1'b0;
        bus.sample_mon_i = '0;

        repeat (3) @(negedge clk);
        check("reset_mon", 64'(bus.mon_o), 64'd0);
        check("reset_err", 64'(bus.err_o), 64'd0);
        check("reset_valid", 64'(bus.mon_valid_o), 64'd0);
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        rst = 1'b0;
        bus.en_i = 1'b1;

        // basic phases 10..13; first sync only arms
        win(100, d1, no, 0, '0, '0, -1);
        check("busy_after_arm", 64'(bus.busy_o), 64'd1);
        repeat (3) win(100, d1, no, 0, '0, '0, -1);
        // truncating average on chip 2: 20+21+22+23 = 86 -> 21
        win(100, c20, no, 1, pack4(10, 11, 12, 13), 4'h0, -1);
        win(100, c21, no, 0, '0, '0, -1);
        win(100, c22, no, 0, '0, '0, -1);
        win(100, c23, no, 0, '0, '0, -1);
        // chip 1 misses one window
        win(100, bad1, no, 1, pack4(10, 11, 21, 13), 4'h0, -1);
        repeat (3) win(100, f5, no, 0, '0, '0, -1);
        // clean average clears err
        win(100, f5, no, 1, pack4(5, 67, 5, 5), 4'b0010, -1);
        repeat (3) win(100, f5, no, 0, '0, '0, -1);
        // glitch edges (only first counts) and edge coincident with sync
        win(100, g1, g2, 1, pack4(5, 5, 5, 5), 4'h0, -1);
        repeat (3) win(100, g1, g2, 0, '0, '0, -1);
        // counter saturation with long sync period
        win(300, s280, no, 1, pack4(5, 0, 7, 9), 4'h0, -1);
        repeat (3) win(300, s280, no, 0, '0, '0, -1);
        // no edges at all
        win(100, no, no, 1, pack4(255, 255, 255, 255), 4'h0, -1);
        repeat (3) win(100, no, no, 0, '0, '0, -1);
        win(100, d1, no, 1, pack4(255, 255, 255, 255), 4'hF, -1);
        win(100, d1, no, 0, '0, '0, -1);

        // drop enable together with a sync: nothing accumulates, outputs hold
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("busy_after_drop", 64'(bus.busy_o), 64'd0);
        check("hold_mon", 64'(bus.mon_o), 64'(pack4(255, 255, 255, 255)));
        check("hold_err", 64'(bus.err_o), 64'hF);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("idle_sync_no_arm", 64'(bus.busy_o), 64'd0);
        bus.en_i = 1'b1;

        // re-arm, first strobe after 5th sync; then reset mid-window
        repeat (4) win(100, d1, no, 0, '0, '0, -1);
        win(100, d1, no, 1, pack4(10, 11, 12, 13), 4'h0, 50);
        check("rst_mid_mon", 64'(bus.mon_o), 64'd0);
        check("rst_mid_err", 64'(bus.err_o), 64'd0);
        check("rst_mid_busy", 64'(bus.busy_o), 64'd0);

        // recovery after reset
        repeat (4) win(100, l1, no, 0, '0, '0, -1);
        win(100, d1, no, 1, pack4(1, 2, 3, 4), 4'h0, -1);
        repeat (20) step(1'b0, 1'b1);
        check("pending_strobes", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
